// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: FIFO controller that acts as the client of a BRAM server.
// The BRAM holds the bulk of the entries. A 2-entry output buffer hides the
// BRAM's one-cycle read latency, so `first` is registered and back-to-back
// dequeues run at full rate. Total capacity is DEPTH + 2 entries.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   enq__ENA/enq_v      enqueue strobe and data; enq__RDY = space available
//   deq__ENA/deq__RDY   dequeue strobe / head valid
//   first/first__RDY    registered head entry and its valid flag
//   count               entries held (BRAM + in-flight read + output buffer)
//   bram_write_*        BRAM write request (combinational from enq)
//   bram_read_*         BRAM read request (decided from registered state)
//   bram_dataOut*       BRAM read return, valid one cycle after a read
module bram_fifo_ctrl #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 48
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         enq__ENA,
  input  logic [WIDTH-1:0]             enq_v,
  output logic                         enq__RDY,
  input  logic                         deq__ENA,
  output logic                         deq__RDY,
  output logic [WIDTH-1:0]             first,
  output logic                         first__RDY,
  output logic [$clog2(DEPTH+3)-1:0]   count,
  output logic                         bram_write__ENA,
  output logic [$clog2(DEPTH)-1:0]     bram_write_addr,
  output logic [WIDTH-1:0]             bram_write_data,
  input  logic                         bram_write__RDY,
  output logic                         bram_read__ENA,
  output logic [$clog2(DEPTH)-1:0]     bram_read_addr,
  input  logic                         bram_read__RDY,
  input  logic [WIDTH-1:0]             bram_dataOut,
  input  logic                         bram_dataOut__RDY
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 3);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    bram_cnt;
  logic             inflight;
  logic [1:0]       ob_cnt;
  logic [WIDTH-1:0] ob_head;
  logic [WIDTH-1:0] ob_tail;

  logic [2:0]       occ;
  logic             read_issue;
  logic             capture;

  // Pointer increment with wrap at DEPTH-1 (DEPTH need not be a power of two).
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Request generation and status, all from registered state plus strobes.
  always_comb begin
    occ        = 3'({1'b0, ob_cnt}) + 3'(inflight);
    // Issue a read only if the buffer still has room for its return after
    // any pop happening this cycle.
    read_issue = (bram_cnt != '0) && bram_read__RDY
                 && (occ < (3'd2 + 3'(deq__ENA)));
    // A return with no read outstanding (e.g. stale across reset) is dropped.
    capture    = bram_dataOut__RDY && inflight;

    enq__RDY        = (bram_cnt < CW'(DEPTH)) && bram_write__RDY;
    bram_write__ENA = enq__ENA;
    bram_write_addr = wr_ptr;
    bram_write_data = enq_v;
    bram_read__ENA  = read_issue;
    bram_read_addr  = rd_ptr;

    first      = ob_head;
    first__RDY = (ob_cnt != 2'd0);
    deq__RDY   = first__RDY;
    count      = bram_cnt + CW'(inflight) + CW'(ob_cnt);
  end

  // Pointers, occupancy counters and the 2-entry output buffer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      bram_cnt <= '0;
      inflight <= 1'b0;
      ob_cnt   <= 2'd0;
      ob_head  <= '0;
      ob_tail  <= '0;
    end else begin
      if (enq__ENA)   wr_ptr <= ptr_inc(wr_ptr);
      if (read_issue) rd_ptr <= ptr_inc(rd_ptr);
      bram_cnt <= bram_cnt + CW'(enq__ENA) - CW'(read_issue);
      inflight <= read_issue || (inflight && !capture);
      ob_cnt   <= ob_cnt + 2'(capture) - 2'(deq__ENA);
      // Pop shifts tail to head; a capture then lands in the first free slot
      // after the pop, overriding the shift when it targets the head.
      if (deq__ENA) ob_head <= ob_tail;
      if (capture) begin
        if ((ob_cnt - 2'(deq__ENA)) == 2'd0) ob_head <= bram_dataOut;
        else                                 ob_tail <= bram_dataOut;
      end
    end
  end

  // Strobes are only legal while the matching ready is high.
  a_enq_protocol: assert property (@(posedge CLK) disable iff (RST) enq__ENA |-> enq__RDY);
  a_deq_protocol: assert property (@(posedge CLK) disable iff (RST) deq__ENA |-> deq__RDY);

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed bench for bram_fifo_ctrl. Two instances (DEPTH=4 and DEPTH=5)
// share one stimulus stream, each attached to its own simple BRAM model.
module tb_bram_fifo_ctrl;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, enq_ena, deq_ena, wr_rdy, rd_rdy, stale;
  logic [W-1:0] enq_v;

  // DEPTH = 4 instance
  logic         e4_rdy, d4_rdy, f4_rdy, w4_ena, r4_ena, v4;
  logic [W-1:0] f4, w4_data, m4_out;
  logic [2:0]   c4;
  logic [1:0]   w4_addr, r4_addr;
  logic [W-1:0] mem4 [4];

  // DEPTH = 5 instance
  logic         e5_rdy, d5_rdy, f5_rdy, w5_ena, r5_ena, v5;
  logic [W-1:0] f5, w5_data, m5_out;
  logic [2:0]   c5;
  logic [2:0]   w5_addr, r5_addr;
  logic [W-1:0] mem5 [8];

  int errors = 0;
  int checks = 0;
  int e, d, r;

  bram_fifo_ctrl #(.DEPTH(4), .WIDTH(W)) u4 (
    .CLK(clk), .RST(rst),
    .enq__ENA(enq_ena), .enq_v(enq_v), .enq__RDY(e4_rdy),
    .deq__ENA(deq_ena), .deq__RDY(d4_rdy),
    .first(f4), .first__RDY(f4_rdy), .count(c4),
    .bram_write__ENA(w4_ena), .bram_write_addr(w4_addr), .bram_write_data(w4_data),
    .bram_write__RDY(wr_rdy),
    .bram_read__ENA(r4_ena), .bram_read_addr(r4_addr), .bram_read__RDY(rd_rdy),
    .bram_dataOut(m4_out), .bram_dataOut__RDY(v4 | stale)
  );

  bram_fifo_ctrl #(.DEPTH(5), .WIDTH(W)) u5 (
    .CLK(clk), .RST(rst),
    .enq__ENA(enq_ena), .enq_v(enq_v), .enq__RDY(e5_rdy),
    .deq__ENA(deq_ena), .deq__RDY(d5_rdy),
    .first(f5), .first__RDY(f5_rdy), .count(c5),
    .bram_write__ENA(w5_ena), .bram_write_addr(w5_addr), .bram_write_data(w5_data),
    .bram_write__RDY(wr_rdy),
    .bram_read__ENA(r5_ena), .bram_read_addr(r5_addr), .bram_read__RDY(rd_rdy),
    .bram_dataOut(m5_out), .bram_dataOut__RDY(v5 | stale)
  );

  // BRAM models: one-cycle read latency, valid pulse follows each read, no reset.
  always_ff @(posedge clk) begin
    if (w4_ena) mem4[w4_addr] <= w4_data;
    if (r4_ena) m4_out <= mem4[r4_addr];
    v4 <= r4_ena;
    if (w5_ena) mem5[w5_addr] <= w5_data;
    if (r5_ena) m5_out <= mem5[r5_addr];
    v5 <= r5_ena;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; enq_ena = 1'b0; deq_ena = 1'b0; enq_v = '0;
    wr_rdy = 1'b1; rd_rdy = 1'b1; stale = 1'b0;
    cyc(); cyc();
    rst = 1'b0;

    // Reset state
    check("rst_count", 32'(c4), 0);
    check("rst_first_rdy", 32'(f4_rdy), 0);
    check("rst_first", 32'(f4), 0);
    check("rst_enq_rdy", 32'(e4_rdy), 1);
    #1;
    check("rst_wr_ena", 32'(w4_ena), 0);
    check("rst_rd_ena", 32'(r4_ena), 0);
    wr_rdy = 1'b0; #1;
    check("enq_rdy_follows_wr_rdy", 32'(e4_rdy), 0);
    wr_rdy = 1'b1;

    // 1: single entry latency
    enq_ena = 1'b1; enq_v = 8'hA5; #1;
    check("t1_wr_ena", 32'(w4_ena), 1);
    check("t1_wr_addr", 32'(w4_addr), 0);
    check("t1_wr_data", 32'(w4_data), 32'h A5);
    check("t1_no_rd", 32'(r4_ena), 0);
    cyc(); enq_ena = 1'b0; #1;
    check("t1_rd_ena", 32'(r4_ena), 1);
    check("t1_rd_addr", 32'(r4_addr), 0);
    check("t1_count_n1", 32'(c4), 1);
    cyc();
    check("t1_not_yet", 32'(f4_rdy), 0);
    cyc();
    check("t1_first_rdy", 32'(f4_rdy), 1);
    check("t1_first", 32'(f4), 32'h A5);
    check("t1_count", 32'(c4), 1);
    deq_ena = 1'b1; cyc(); deq_ena = 1'b0;
    check("t1_count_after", 32'(c4), 0);
    check("t1_empty_after", 32'(f4_rdy), 0);

    // 2: fill DEPTH=4 instance to DEPTH+2, then drain
    for (int i = 0; i < 6; i++) begin
      enq_ena = 1'b1; enq_v = W'(i); #1;
      check("t2_fill_rdy", 32'(e4_rdy), 1);
      cyc();
    end
    enq_ena = 1'b0;
    cyc(); cyc(); cyc();
    check("t2_count4", 32'(c4), 6);
    check("t2_full4", 32'(e4_rdy), 0);
    check("t2_bram_cnt4", 32'(u4.bram_cnt), 4);
    check("t2_count5", 32'(c5), 6);
    check("t2_notfull5", 32'(e5_rdy), 1);
    for (int i = 0; i < 6; i++) begin
      deq_ena = 1'b1; #1;
      check("t2_drain_rdy", 32'(f4_rdy), 1);
      check("t2_drain_data", 32'(f4), 32'(i));
      if (i == 0) check("t2_full_deq_comb", 32'(e4_rdy), 0);
      if (i == 1) check("t2_full_released", 32'(e4_rdy), 1);
      cyc();
    end
    deq_ena = 1'b0;
    check("t2_count_end", 32'(c4), 0);

    // 3: streaming after a 3-entry prime
    for (int i = 0; i < 3; i++) begin
      enq_ena = 1'b1; enq_v = W'(i); cyc();
    end
    for (int i = 0; i < 20; i++) begin
      enq_ena = 1'b1; enq_v = W'(i + 3); deq_ena = 1'b1; #1;
      check("t3_rdy", 32'(f4_rdy), 1);
      check("t3_data", 32'(f4), 32'(i));
      check("t3_count", 32'(c4), 3);
      cyc();
    end
    enq_ena = 1'b0;
    for (int i = 20; i < 23; i++) begin
      deq_ena = 1'b1; #1;
      check("t3_tail_rdy", 32'(f4_rdy), 1);
      check("t3_tail_data", 32'(f4), 32'(i));
      cyc();
    end
    deq_ena = 1'b0;
    check("t3_count_end", 32'(c4), 0);

    // 4: pointer wrap, 12 enq/deq pairs
    rst = 1'b1; cyc(); rst = 1'b0;
    e = 0; d = 0; r = 0;
    for (int k = 0; k < 40 && d < 12; k++) begin
      enq_ena = (e < 12); enq_v = W'(8'h40 + e); deq_ena = f5_rdy; #1;
      if (enq_ena) begin
        check("t4_wr_addr5", 32'(w5_addr), 32'(e % 5));
        check("t4_wr_addr4", 32'(w4_addr), 32'(e % 4));
        e++;
      end
      if (r5_ena) begin
        check("t4_rd_addr5", 32'(r5_addr), 32'(r % 5));
        check("t4_rd_addr4", 32'(r4_addr), 32'(r % 4));
        r++;
      end
      if (deq_ena) begin
        check("t4_data", 32'(f5), 32'(8'h40 + d));
        d++;
      end
      cyc();
    end
    enq_ena = 1'b0; deq_ena = 1'b0;
    check("t4_deqs", 32'(d), 12);
    check("t4_reads", 32'(r), 12);
    check("t4_count_end", 32'(c5), 0);

    // 5: read backpressure
    rd_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      enq_ena = 1'b1; enq_v = W'(8'h70 + i); #1;
      check("t5_no_read_enq", 32'(r5_ena), 0);
      cyc();
    end
    enq_ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t5_no_read", 32'(r5_ena), 0);
      check("t5_no_first", 32'(f5_rdy), 0);
      cyc();
    end
    check("t5_count", 32'(c5), 3);
    rd_rdy = 1'b1; #1;
    check("t5_read_released", 32'(r5_ena), 1);
    check("t5_rd_addr5", 32'(r5_addr), 2);
    check("t5_rd_addr4", 32'(r4_addr), 0);
    cyc();
    check("t5_first_wait", 32'(f5_rdy), 0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      deq_ena = 1'b1; #1;
      check("t5_rdy", 32'(f5_rdy), 1);
      check("t5_data", 32'(f5), 32'(8'h70 + i));
      cyc();
    end
    deq_ena = 1'b0;
    check("t5_count_end", 32'(c5), 0);

    // 6: reset while a read is in flight, then stale return pulse
    enq_ena = 1'b1; enq_v = 8'h11; cyc();
    enq_ena = 1'b0; #1;
    check("t6_read", 32'(r5_ena), 1);
    cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    check("t6_first_rdy5", 32'(f5_rdy), 0);
    check("t6_count5", 32'(c5), 0);
    check("t6_first_rdy4", 32'(f4_rdy), 0);
    check("t6_count4", 32'(c4), 0);
    stale = 1'b1; cyc(); stale = 1'b0;
    check("t6_stale_ignored", 32'(f5_rdy), 0);
    check("t6_stale_count", 32'(c5), 0);
    enq_ena = 1'b1; enq_v = 8'h3C; #1;
    check("t6_wr_addr", 32'(w5_addr), 0);
    cyc(); enq_ena = 1'b0; #1;
    check("t6_rd_ena", 32'(r5_ena), 1);
    check("t6_rd_addr", 32'(r5_addr), 0);
    cyc(); cyc();
    check("t6_first_rdy", 32'(f5_rdy), 1);
    check("t6_first", 32'(f5), 32'h 3C);
    check("t6_count", 32'(c5), 1);
    deq_ena = 1'b1; cyc(); deq_ena = 1'b0;
    check("t6_count_end", 32'(c5), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_fifo_ctrl.md
Name: bram_fifo_ctrl

Overview:
- FIFO controller that sits directly upstream of a BRAM server and acts as its client. It drives the BRAM write/read methods and consumes the BRAM's dataOut.
- Presents an enq/deq/first method interface to the datapath.
- Hides the BRAM's one-cycle read latency behind a 2-entry output buffer, so `first` is registered and back-to-back deq runs at full rate.
- Total capacity is DEPTH + 2 entries.

Parameters:
- DEPTH, 1024: BRAM entries. Any value ≥ 2; need not be a power of two.
- WIDTH, 48: data width in bits.

Ports:
- CLK  input  1  clock; all state on rising edge.
- RST  input  1  synchronous, active-high reset.
- enq__ENA  input  1  enqueue strobe; legal only when enq__RDY is high.
- enq$v  input  WIDTH  enqueue data.
- enq__RDY  output  1  space available.
- deq__ENA  input  1  dequeue strobe; legal only when deq__RDY is high.
- deq__RDY  output  1  head entry valid; equals first__RDY.
- first  output  WIDTH  head entry, registered.
- first__RDY  output  1  first is valid.
- count  output  $clog2(DEPTH+3)  total entries held (BRAM + output buffer).
- bram$write__ENA  output  1  BRAM write strobe.
- bram$write$addr  output  $clog2(DEPTH)  BRAM write address.
- bram$write$data  output  WIDTH  BRAM write data.
- bram$write__RDY  input  1  BRAM can accept a write.
- bram$read__ENA  output  1  BRAM read strobe.
- bram$read$addr  output  $clog2(DEPTH)  BRAM read address.
- bram$read__RDY  input  1  BRAM can accept a read.
- bram$dataOut  input  WIDTH  BRAM read data.
- bram$dataOut__RDY  input  1  bram$dataOut valid; asserted exactly one cycle after an accepted read.

Behaviour:
- **Reset** (RST high at a clock edge) clears: wr_ptr, rd_ptr, bram_cnt, inflight, ob_cnt.
  - After reset: enq__RDY = bram$write__RDY; first__RDY = 0; count = 0; bram$write__ENA = 0; bram$read__ENA = 0; first = 0.
- **Enqueue path:**
  - enq__RDY = (bram_cnt < DEPTH) && bram$write__RDY.
  - On enq__ENA, in the same cycle, combinationally: bram$write__ENA = 1, addr = wr_ptr, data = enq$v.
  - wr_ptr increments, wrapping from DEPTH-1 to 0.
- **Read issue:**
  - bram$read__ENA = (bram_cnt > 0) && bram$read__RDY && (ob_cnt + inflight − (deq__ENA ? 1 : 0) < 2).
  - bram$read$addr = rd_ptr; rd_ptr wraps from DEPTH-1 to 0.
  - bram_cnt and the read decision use registered state only. A write in cycle N is read no earlier than cycle N+1; no write-to-read bypass.
- **Capture:**
  - When bram$dataOut__RDY is high and inflight is 1, bram$dataOut is pushed into the output buffer at the end of the cycle and inflight clears.
  - bram$dataOut__RDY is ignored while inflight is 0. This covers a stale return after reset.
- **Output buffer:**
  - 2-entry FIFO; first = head register; first__RDY = (ob_cnt > 0).
  - deq__ENA pops the head. The second entry moves to the head in the same edge.
  - A simultaneous capture and pop keeps ob_cnt unchanged and preserves order.
- **Counters, per edge:**
  - bram_cnt += enq − read_issue.
  - ob_cnt += capture − deq.
  - inflight ∈ {0,1}.
  - count = bram_cnt + inflight + ob_cnt.
- **Latency:**
  - enq at cycle N on an empty FIFO: write N, read N+1, dataOut N+2, first__RDY high in N+3.
  - Steady-state throughput: 1 enq + 1 deq per cycle.
- **Full:**
  - When bram_cnt = DEPTH, enq__RDY is low.
  - A deq in the same cycle does not raise enq__RDY combinationally; it rises the next cycle once a read has drained the BRAM.
- **Simultaneous enq and read at the same address:** impossible, because the read requires the registered bram_cnt > 0.
- **Protocol errors:** enq__ENA while enq__RDY is low, or deq__ENA while deq__RDY is low, is a protocol error and is flagged by a simulation assertion. The RTL behaviour is undefined.
- **Reset mid-operation:**
  - All state clears in one cycle; in-flight data is discarded.
  - BRAM contents are not cleared and need not be.

Test Plan:
1. Reset, then enq 0xA5 at cycle 10 → bram$write__ENA at cycle 10 with addr 0; bram$read__ENA at 11 with addr 0; first__RDY=1, first=0xA5, count=1 at 13; deq at 13 → count=0, first__RDY=0 at 14.
2. Fill with DEPTH=4: enq 0,1,…,5, no deq → count=6, enq__RDY=0 after six enqs, bram_cnt=4. Deq six times → values 0..5 in order, count returns to 0.
3. Streaming: enq and deq every cycle for 20 cycles after an initial 3-cycle prime → no bubbles, output order 0..19, count stays constant.
4. Pointer wrap with DEPTH=5 (non-power-of-two): 12 enq/deq pairs → write and read addresses follow 0,1,2,3,4,0,…; data order preserved.
5. Backpressure: hold bram$read__RDY=0 for 5 cycles with 3 entries queued → no bram$read__ENA and first__RDY stays 0; on release, reads are issued and the first valid value appears 2 cycles later.
6. Reset asserted the cycle after bram$read__ENA → the bram$dataOut__RDY pulse that follows is ignored; first__RDY=0, count=0; a fresh enq of 0x3C returns 0x3C.
